// File: rtl/sr_serializer_mc_pkg.sv
// Shared types, sizing helper and parameter legality check for the serial link blocks.
package sr_serializer_mc_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // Bits needed to hold values 0..n-1; never less than one bit.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 1;
    while ((32'd1 << r) < n) r++;
    return r;
  endfunction

  // True when the serializer parameters describe a buildable configuration.
  function automatic bit params_ok(input int unsigned div, input int unsigned width,
                                   input int unsigned channels, input int unsigned msb_first);
    return (div >= 2) && (width >= 2) && (channels >= 1) && (msb_first <= 1);
  endfunction

endpackage

// File: rtl/sr_clk_div.sv
// Free-running bit-clock divider: one tick per DIV clocks plus a registered divided clock.
module sr_clk_div
  import sr_serializer_mc_pkg::*;
#(
  parameter int unsigned DIV = 4
) (
  input  logic clk_in,
  input  logic rst_n,
  output logic tick_c,
  output logic clk_div
);

  localparam int unsigned CW   = clog2(DIV);
  localparam int unsigned HALF = DIV / 2;

  if (DIV < 2) begin : g_div_check
    $error("sr_clk_div: DIV must be at least 2");
  end

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          clk_div_nxt;

  // Terminal count, wrap, and divided-clock level for the coming count value.
  // clk_div only rises on a tick, so it stays low until the first full period after reset.
  always_comb begin
    tick_c      = (cnt == CW'(DIV - 1));
    cnt_nxt     = tick_c ? '0 : cnt + CW'(1);
    clk_div_nxt = (cnt_nxt < CW'(HALF)) && (tick_c || clk_div);
  end

  // Counter and divided-clock registers.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      clk_div <= 1'b0;
    end else begin
      cnt     <= cnt_nxt;
      clk_div <= clk_div_nxt;
    end
  end

endmodule

// File: rtl/sr_serializer_mc.sv
// Multi-lane parallel-to-serial shifter with a one-word holding buffer and integrated bit clock.
module sr_serializer_mc
  import sr_serializer_mc_pkg::*;
#(
  parameter int unsigned DIV       = 4,
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned CHANNELS  = 2,
  parameter int unsigned MSB_FIRST = 1
) (
  input  logic                      clk_in,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] load_data,
  input  logic                      load_valid,
  output logic                      load_ready,
  output logic [CHANNELS-1:0]       sr_out,
  output logic                      clk_div,
  output logic                      frame_out,
  output logic                      busy
);

  localparam int unsigned BCW = clog2(WIDTH + 1);

  if (!params_ok(DIV, WIDTH, CHANNELS, MSB_FIRST)) begin : g_param_check
    $error("sr_serializer_mc: illegal parameter combination");
  end

  logic                      tick_c;
  state_e                    state;
  state_e                    state_nxt;
  logic                      hold_valid;
  logic                      hold_valid_nxt;
  logic [CHANNELS*WIDTH-1:0] hold_data;
  logic [BCW-1:0]            bitcnt;
  logic [BCW-1:0]            bitcnt_nxt;
  logic                      frame_nxt;
  logic                      busy_nxt;
  logic                      accept_c;
  logic                      load_sh_c;
  logic                      shift_c;
  logic                      clear_c;

  sr_clk_div #(
    .DIV(DIV)
  ) u_clk_div (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .tick_c (tick_c),
    .clk_div(clk_div)
  );

  assign load_ready = ~hold_valid;

  // Next-state logic: buffer fill on handshake, buffer drain and bit stepping on ticks.
  always_comb begin
    state_nxt      = state;
    hold_valid_nxt = hold_valid;
    bitcnt_nxt     = bitcnt;
    frame_nxt      = frame_out;
    accept_c       = load_valid && !hold_valid;
    load_sh_c      = 1'b0;
    shift_c        = 1'b0;
    clear_c        = 1'b0;

    if (accept_c) begin
      hold_valid_nxt = 1'b1;
    end

    case (state)
      IDLE: begin
        if (tick_c) begin
          if (hold_valid) begin
            load_sh_c      = 1'b1;
            hold_valid_nxt = 1'b0;
            frame_nxt      = 1'b1;
            bitcnt_nxt     = BCW'(1);
            state_nxt      = SHIFT;
          end else begin
            clear_c   = 1'b1;
            frame_nxt = 1'b0;
          end
        end
      end
      SHIFT: begin
        if (tick_c) begin
          if (bitcnt == BCW'(WIDTH)) begin
            if (hold_valid) begin
              load_sh_c      = 1'b1;
              hold_valid_nxt = 1'b0;
              frame_nxt      = 1'b1;
              bitcnt_nxt     = BCW'(1);
            end else begin
              clear_c   = 1'b1;
              frame_nxt = 1'b0;
              state_nxt = IDLE;
            end
          end else begin
            shift_c    = 1'b1;
            frame_nxt  = 1'b0;
            bitcnt_nxt = bitcnt + BCW'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    busy_nxt = (state_nxt == SHIFT) || hold_valid_nxt;
  end

  // Control state registers.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      hold_valid <= 1'b0;
      bitcnt     <= '0;
      frame_out  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      hold_valid <= hold_valid_nxt;
      bitcnt     <= bitcnt_nxt;
      frame_out  <= frame_nxt;
      busy       <= busy_nxt;
    end
  end

  // Holding buffer captures the word on each accepted handshake.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      hold_data <= '0;
    end else if (accept_c) begin
      hold_data <= load_data;
    end
  end

  // Per-lane shift registers, all stepped by the shared load/shift/clear strobes.
  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    logic [WIDTH-1:0] word;
    logic [WIDTH-1:0] shreg;
    logic             bit_q;

    assign word      = hold_data[c*WIDTH +: WIDTH];
    assign sr_out[c] = bit_q;

    if (MSB_FIRST != 0) begin : g_msb
      // MSB leaves first; remaining bits move toward the top.
      always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
          shreg <= '0;
          bit_q <= 1'b0;
        end else if (load_sh_c) begin
          bit_q <= word[WIDTH-1];
          shreg <= {word[WIDTH-2:0], 1'b0};
        end else if (shift_c) begin
          bit_q <= shreg[WIDTH-1];
          shreg <= {shreg[WIDTH-2:0], 1'b0};
        end else if (clear_c) begin
          bit_q <= 1'b0;
        end
      end
    end else begin : g_lsb
      // LSB leaves first; remaining bits move toward the bottom.
      always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
          shreg <= '0;
          bit_q <= 1'b0;
        end else if (load_sh_c) begin
          bit_q <= word[0];
          shreg <= {1'b0, word[WIDTH-1:1]};
        end else if (shift_c) begin
          bit_q <= shreg[0];
          shreg <= {1'b0, shreg[WIDTH-1:1]};
        end else if (clear_c) begin
          bit_q <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_sr_serializer_mc.sv
// Bench for sr_serializer_mc: two configurations checked every cycle against a frame-timeline model.
module tb_sr_serializer_mc;

  localparam int DIV_A = 4;
  localparam int W_A   = 8;
  localparam int CH_A  = 2;
  localparam int MSB_A = 1;
  localparam int DIV_B = 3;
  localparam int W_B   = 16;
  localparam int CH_B  = 3;
  localparam int MSB_B = 0;
  localparam int MAXF  = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst_a, rst_b, va, vb;
  logic [CH_A*W_A-1:0]  da;
  logic [CH_B*W_B-1:0]  db;
  logic                 rdy_a, rdy_b, ck_a, ck_b, fr_a, fr_b, bz_a, bz_b;
  logic [CH_A-1:0]      sr_a;
  logic [CH_B-1:0]      sr_b;

  sr_serializer_mc #(.DIV(DIV_A), .WIDTH(W_A), .CHANNELS(CH_A), .MSB_FIRST(MSB_A)) dut_a (
    .clk_in(clk), .rst_n(rst_a), .load_data(da), .load_valid(va), .load_ready(rdy_a),
    .sr_out(sr_a), .clk_div(ck_a), .frame_out(fr_a), .busy(bz_a));

  sr_serializer_mc #(.DIV(DIV_B), .WIDTH(W_B), .CHANNELS(CH_B), .MSB_FIRST(MSB_B)) dut_b (
    .clk_in(clk), .rst_n(rst_b), .load_data(db), .load_valid(vb), .load_ready(rdy_b),
    .sr_out(sr_b), .clk_div(ck_b), .frame_out(fr_b), .busy(bz_b));

  int total = 0;
  int bad   = 0;

  // Model: per instance, edges since reset release and the scheduled frames
  // (accept edge, first-bit edge, word). Everything else is derived arithmetically.
  int          tcnt[2];
  int          nfr[2];
  int          st[2][MAXF];
  int          acc[2][MAXF];
  logic [63:0] wd[2][MAXF];

  function automatic int p_div(int i); return (i == 0) ? DIV_A : DIV_B; endfunction
  function automatic int p_w(int i);   return (i == 0) ? W_A : W_B;     endfunction
  function automatic int p_ch(int i);  return (i == 0) ? CH_A : CH_B;   endfunction
  function automatic int p_msb(int i); return (i == 0) ? MSB_A : MSB_B; endfunction

  function automatic bit held(int i, int t);
    for (int f = 0; f < nfr[i]; f++)
      if (acc[i][f] <= t && t < st[i][f]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int frame_at(int i, int t);
    for (int f = 0; f < nfr[i]; f++)
      if (st[i][f] <= t && t < st[i][f] + p_w(i) * p_div(i)) return f;
    return -1;
  endfunction

  // A word accepted at edge t starts at the next tick, or when the running frame ends.
  task automatic record(int i, logic [63:0] w);
    int t, s, le;
    t = tcnt[i];
    s = (t / p_div(i) + 1) * p_div(i);
    if (nfr[i] > 0) begin
      le = st[i][nfr[i]-1] + p_w(i) * p_div(i);
      if (le > s) s = le;
    end
    if (nfr[i] < MAXF) begin
      st[i][nfr[i]]  = s;
      acc[i][nfr[i]] = t;
      wd[i][nfr[i]]  = w;
      nfr[i]++;
    end
  endtask

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check(int i);
    int t, f, k, pos;
    logic [63:0] e_sr, o_sr;
    logic o_fr, o_bz, o_rd, o_ck;
    t    = tcnt[i];
    f    = frame_at(i, t);
    e_sr = '0;
    if (f >= 0) begin
      k = (t - st[i][f]) / p_div(i);
      for (int c = 0; c < p_ch(i); c++) begin
        pos = (p_msb(i) != 0) ? (p_w(i) - 1 - k) : k;
        e_sr[c] = wd[i][f][c * p_w(i) + pos];
      end
    end
    if (i == 0) begin
      o_sr = 64'(sr_a); o_fr = fr_a; o_bz = bz_a; o_rd = rdy_a; o_ck = ck_a;
    end else begin
      o_sr = 64'(sr_b); o_fr = fr_b; o_bz = bz_b; o_rd = rdy_b; o_ck = ck_b;
    end
    chk($sformatf("i%0d_t%0d_sr_out", i, t), o_sr, e_sr);
    chk($sformatf("i%0d_t%0d_frame_out", i, t), 64'(o_fr),
        64'((f >= 0) && (t - st[i][f] < p_div(i))));
    chk($sformatf("i%0d_t%0d_busy", i, t), 64'(o_bz), 64'((f >= 0) || held(i, t)));
    chk($sformatf("i%0d_t%0d_load_ready", i, t), 64'(o_rd), 64'(!held(i, t)));
    chk($sformatf("i%0d_t%0d_clk_div", i, t), 64'(o_ck),
        64'((t >= p_div(i)) && ((t % p_div(i)) < p_div(i) / 2)));
  endtask

  // One clock: predict handshakes, advance the model, then check both instances.
  task automatic step();
    bit acc_a, acc_b;
    acc_a = va && rst_a && !held(0, tcnt[0]);
    acc_b = vb && rst_b && !held(1, tcnt[1]);
    @(posedge clk);
    if (rst_a) begin
      tcnt[0]++;
      if (acc_a) record(0, 64'(da));
    end
    if (rst_b) begin
      tcnt[1]++;
      if (acc_b) record(1, 64'(db));
    end
    #1;
    check(0);
    check(1);
  endtask

  task automatic send(int i, logic [63:0] w);
    bit ok, rdy;
    ok = 1'b0;
    if (i == 0) begin va = 1'b1; da = w[CH_A*W_A-1:0]; end
    else        begin vb = 1'b1; db = w[CH_B*W_B-1:0]; end
    for (int k = 0; k < 200 && !ok; k++) begin
      rdy = !held(i, tcnt[i]);
      step();
      if (rdy) ok = 1'b1;
    end
    va = 1'b0;
    vb = 1'b0;
    chk($sformatf("i%0d_accept", i), 64'(ok), 64'd1);
  endtask

  initial begin
    int s, gap, inst;
    logic [63:0] r;
    rst_a = 1'b0; rst_b = 1'b0; va = 1'b0; vb = 1'b0; da = '0; db = '0;
    for (int i = 0; i < 2; i++) begin tcnt[i] = 0; nfr[i] = 0; end

    // Reset held 5 cycles, then release.
    repeat (5) step();
    rst_a = 1'b1; rst_b = 1'b1;
    repeat (2) step();

    // Single word on A: lane0 0xA5, lane1 0x3C.
    send(0, 64'h3CA5);
    repeat (40) step();

    // Back-to-back 0xFF then 0x00 on A.
    send(0, 64'hFFFF);
    send(0, 64'h0000);
    repeat (80) step();

    // LSB-first on B with a single set bit per lane.
    send(1, 64'h0001_0001_0001);
    repeat (60) step();

    // Random words, random instance, mix of back-to-back and idle gaps.
    for (int n = 0; n < 24; n++) begin
      inst = int'($urandom_range(0, 1));
      r    = {$urandom, $urandom};
      gap  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 60)) : int'($urandom_range(0, 3));
      repeat (gap) step();
      send(inst, r);
    end
    repeat (120) step();

    // Reset A after three bits of 0xA5 have been shifted.
    send(0, 64'hA5A5);
    s = st[0][nfr[0]-1] + 3 * DIV_A;
    for (int k = 0; k < 100 && tcnt[0] < s; k++) step();
    chk("mid_reset_reached", 64'(tcnt[0] >= s), 64'd1);
    rst_a   = 1'b0;
    nfr[0]  = 0;
    tcnt[0] = 0;
    #1;
    check(0);
    repeat (3) step();
    rst_a = 1'b1;
    repeat (40) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
